ss_enc_slave_emulator: RTL and testbench

SSI absolute-encoder slave emulator for FPGA2's SS Enc digital interface pins. It is the responder end of the SSI link: an external SSI master clocks `ss_enc_clk_in`, and this block latches a DSP-supplied position word and shifts it out MSB-first on `ss_enc_do`, then enforces the monoflop (tm) pause. It sits beside the bus-register logic, which supplies position, mode and enable and reads back status.

---
 rtl/ss_enc_pkg.sv | 19 +
 rtl/ss_enc_clk_sync.sv | 37 +++
 rtl/ss_enc_slave_emulator.sv | 169 ++++++++++++++++
 tb/tb_ss_enc_slave_emulator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ss_enc_pkg.sv
// Shared definitions for the SSI encoder slave emulator and its clock-side helpers.
// Provides state encoding, default timing constants and the Gray-code conversion.
package ss_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MONO  = 2'd2
    } ss_state_e;

    // 20 us monoflop and 100 us mid-frame silence at 75 MHz
    localparam int TM_CYCLES_DEF    = 1500;
    localparam int ABORT_CYCLES_DEF = 7500;

    function automatic logic [31:0] gray_encode(input logic [31:0] bin);
        return bin ^ (bin >> 5'd1);
    endfunction

endpackage

// File: rtl/ss_enc_clk_sync.sv
// Brings an asynchronous SSI clock into the local domain and emits one-cycle
// registered rise/fall pulses; also usable by the master-side reader.
module ss_enc_clk_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic sync3_r;
    logic rise_r;
    logic fall_r;

    // Two-flop synchronizer, history stage and registered edge pulses; the idle line level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            sync3_r <= 1'b1;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            rise_r  <= sync2_r & ~sync3_r;
            fall_r  <= ~sync2_r & sync3_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/ss_enc_slave_emulator.sv
// SSI absolute-encoder slave: latches a position word on the master's first falling
// clock, shifts it out MSB-first on rising clocks, then holds the monoflop pause.
module ss_enc_slave_emulator
    import ss_enc_pkg::*;
#(
    parameter int DATA_BITS    = 13,
    parameter int TM_CYCLES    = TM_CYCLES_DEF,
    parameter int ABORT_CYCLES = ABORT_CYCLES_DEF
) (
    input  logic                 clk75Mhz,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 gray_en,
    input  logic [DATA_BITS-1:0] position_in,
    input  logic                 ss_enc_clk_in,
    output logic                 ss_enc_clk_dir,
    output logic                 ss_enc_clk_out,
    output logic                 ss_enc_dat_dir,
    output logic                 ss_enc_do,
    output logic                 busy,
    output logic [15:0]          frame_count,
    output logic [7:0]           abort_count
);

    localparam int TW = $clog2(ABORT_CYCLES);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TM_LAST    = TW'(TM_CYCLES - 1);
    localparam logic [TW-1:0] ABORT_LAST = TW'(ABORT_CYCLES - 1);

    logic                 rise_s;
    logic                 fall_s;
    logic [DATA_BITS-1:0] word_s;

    ss_state_e            state_r,  state_nxt;
    logic [TW-1:0]        timer_r,  timer_nxt;
    logic [CW-1:0]        cnt_r,    cnt_nxt;
    logic [DATA_BITS-1:0] shreg_r,  shreg_nxt;
    logic                 do_r,     do_nxt;
    logic [15:0]          frame_r,  frame_nxt;
    logic [7:0]           abort_r,  abort_nxt;
    logic                 busy_r;
    logic                 dat_dir_r;

    ss_enc_clk_sync u_clk_sync (
        .clk      (clk75Mhz),
        .rst_n    (reset),
        .async_in (ss_enc_clk_in),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    // Word captured at frame start, optionally Gray-coded
    always_comb begin
        if (gray_en) begin
            word_s = DATA_BITS'(gray_encode(32'(position_in)));
        end else begin
            word_s = position_in;
        end
    end

    // Frame sequencing: one timer serves as the SHIFT abort watchdog and the MONO monoflop
    always_comb begin
        state_nxt = state_r;
        timer_nxt = timer_r;
        cnt_nxt   = cnt_r;
        shreg_nxt = shreg_r;
        do_nxt    = do_r;
        frame_nxt = frame_r;
        abort_nxt = abort_r;
        if (!enable) begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
            do_nxt    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    do_nxt    = 1'b1;
                    timer_nxt = '0;
                    if (fall_s) begin
                        shreg_nxt = word_s;
                        cnt_nxt   = CW'(DATA_BITS);
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (rise_s) begin
                        timer_nxt = '0;
                        if (cnt_r == '0) begin
                            do_nxt    = 1'b0;
                            state_nxt = ST_MONO;
                        end else begin
                            do_nxt    = shreg_r[DATA_BITS-1];
                            shreg_nxt = shreg_r << 5'd1;
                            cnt_nxt   = cnt_r - CW'(1'b1);
                        end
                    end else if (fall_s) begin
                        timer_nxt = '0;
                    end else if (timer_r == ABORT_LAST) begin
                        timer_nxt = '0;
                        do_nxt    = 1'b1;
                        state_nxt = ST_IDLE;
                        if (abort_r != 8'hFF) begin
                            abort_nxt = abort_r + 8'd1;
                        end else begin
                            abort_nxt = abort_r;
                        end
                    end else begin
                        timer_nxt = timer_r + TW'(1'b1);
                    end
                end
                ST_MONO: begin
                    do_nxt = 1'b0;
                    // Any clock activity during the pause stretches it
                    if (rise_s || fall_s) begin
                        timer_nxt = '0;
                    end else if (timer_r == TM_LAST) begin
                        timer_nxt = '0;
                        do_nxt    = 1'b1;
                        frame_nxt = frame_r + 16'd1;
                        state_nxt = ST_IDLE;
                    end else begin
                        timer_nxt = timer_r + TW'(1'b1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    timer_nxt = '0;
                    do_nxt    = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk75Mhz or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            timer_r   <= '0;
            cnt_r     <= '0;
            shreg_r   <= '0;
            do_r      <= 1'b1;
            frame_r   <= 16'd0;
            abort_r   <= 8'd0;
            busy_r    <= 1'b0;
            dat_dir_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            timer_r   <= timer_nxt;
            cnt_r     <= cnt_nxt;
            shreg_r   <= shreg_nxt;
            do_r      <= do_nxt;
            frame_r   <= frame_nxt;
            abort_r   <= abort_nxt;
            busy_r    <= (state_nxt != ST_IDLE);
            dat_dir_r <= enable;
        end
    end

    assign ss_enc_clk_dir = 1'b0;
    assign ss_enc_clk_out = 1'b1;
    assign ss_enc_dat_dir = dat_dir_r;
    assign ss_enc_do      = do_r;
    assign busy           = busy_r;
    assign frame_count    = frame_r;
    assign abort_count    = abort_r;

endmodule

// File: tb/tb_ss_enc_slave_emulator.sv
// Bench for the SSI slave emulator: a 1 MHz master model drives frames from a vector
// table; a monitor pops expected serial bits from a scoreboard queue after each rise.
module tb_ss_enc_slave_emulator;

    localparam int DB      = 13;
    localparam int TM      = 1500;
    localparam int AB      = 7500;
    localparam int LAT     = 4;
    localparam int HALF_LO = 37;
    localparam int HALF_HI = 38;

    logic          clk75Mhz = 1'b0;
    logic          reset;
    logic          enable;
    logic          gray_en;
    logic [DB-1:0] position_in;
    logic          ss_enc_clk_in;
    logic          ss_enc_clk_dir;
    logic          ss_enc_clk_out;
    logic          ss_enc_dat_dir;
    logic          ss_enc_do;
    logic          busy;
    logic [15:0]   frame_count;
    logic [7:0]    abort_count;

    int   errors = 0;
    int   checks = 0;
    int   fc_exp = 0;
    int   ac_exp = 0;
    logic exp_q[$];

    typedef struct {
        logic          gray;
        logic [DB-1:0] pos;
        logic [DB-1:0] exp_word;
    } vec_t;
    vec_t vecs[5];

    ss_enc_slave_emulator #(.DATA_BITS(DB), .TM_CYCLES(TM), .ABORT_CYCLES(AB)) dut (
        .clk75Mhz       (clk75Mhz),
        .reset          (reset),
        .enable         (enable),
        .gray_en        (gray_en),
        .position_in    (position_in),
        .ss_enc_clk_in  (ss_enc_clk_in),
        .ss_enc_clk_dir (ss_enc_clk_dir),
        .ss_enc_clk_out (ss_enc_clk_out),
        .ss_enc_dat_dir (ss_enc_dat_dir),
        .ss_enc_do      (ss_enc_do),
        .busy           (busy),
        .frame_count    (frame_count),
        .abort_count    (abort_count)
    );

    always #7 clk75Mhz = ~clk75Mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Serial output monitor: each master rise is checked well after the 4-cycle latency
    initial begin
        forever begin
            @(posedge ss_enc_clk_in);
            repeat (6) @(negedge clk75Mhz);
            if (exp_q.size() > 0) begin
                logic e;
                e = exp_q.pop_front();
                check("serial_bit", 32'(ss_enc_do), 32'(e));
            end
        end
    end

    task automatic partial_frame(input logic [DB-1:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            ss_enc_clk_in = 1'b0;
            repeat (HALF_LO) @(negedge clk75Mhz);
            ss_enc_clk_in = 1'b1;
            exp_q.push_back(word[DB-1-i]);
            if (i < n - 1) repeat (HALF_HI) @(negedge clk75Mhz);
        end
    endtask

    task automatic run_frame(input logic [DB-1:0] word, input int mono_fall,
                             input logic chg, input logic [DB-1:0] new_pos);
        int k;
        for (int i = 0; i <= DB; i++) begin
            ss_enc_clk_in = 1'b0;
            if (i == 0) begin
                repeat (14) @(negedge clk75Mhz);
                check("busy_in_frame", 32'(busy), 32'd1);
                if (chg) position_in = new_pos;
                repeat (HALF_LO - 14) @(negedge clk75Mhz);
            end else begin
                repeat (HALF_LO) @(negedge clk75Mhz);
            end
            ss_enc_clk_in = 1'b1;
            exp_q.push_back((i < DB) ? word[DB-1-i] : 1'b0);
            if (i < DB) repeat (HALF_HI) @(negedge clk75Mhz);
        end
        fc_exp++;
        if (mono_fall > 0) begin
            repeat (mono_fall) @(negedge clk75Mhz);
            check("mono_do_low", 32'(ss_enc_do), 32'd0);
            ss_enc_clk_in = 1'b0;
            k = 0;
        end else begin
            repeat (6) @(negedge clk75Mhz);
            k = 6;
        end
        while (ss_enc_do !== 1'b1 && k < 5000) begin
            @(negedge clk75Mhz);
            k++;
        end
        check("tm_cycles", 32'(k), 32'(LAT + TM));
        check("frame_count", 32'(frame_count), 32'(fc_exp));
        check("busy_after_frame", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (mono_fall > 0) begin
            ss_enc_clk_in = 1'b1;
            repeat (20) @(negedge clk75Mhz);
            check("rise_in_idle_busy", 32'(busy), 32'd0);
            check("rise_in_idle_do", 32'(ss_enc_do), 32'd1);
        end
    endtask

    initial begin
        int k;
        vecs[0] = '{1'b0, 13'h0A5C, 13'h0A5C};
        vecs[1] = '{1'b1, 13'h0A5C, 13'h0F72};
        vecs[2] = '{1'b0, 13'h1FFF, 13'h1FFF};
        vecs[3] = '{1'b1, 13'h1FFF, 13'h1000};
        vecs[4] = '{1'b1, 13'h1555, 13'h1FFF};

        reset         = 1'b0;
        enable        = 1'b0;
        gray_en       = 1'b0;
        position_in   = 13'h0000;
        ss_enc_clk_in = 1'b1;
        repeat (3) @(negedge clk75Mhz);
        check("rst_do", 32'(ss_enc_do), 32'd1);
        check("rst_dat_dir", 32'(ss_enc_dat_dir), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_abort_count", 32'(abort_count), 32'd0);
        check("clk_dir", 32'(ss_enc_clk_dir), 32'd0);
        check("clk_out", 32'(ss_enc_clk_out), 32'd1);

        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk75Mhz);
        check("dat_dir_on", 32'(ss_enc_dat_dir), 32'd1);
        check("idle_do", 32'(ss_enc_do), 32'd1);

        for (int v = 0; v < 5; v++) begin
            gray_en     = vecs[v].gray;
            position_in = vecs[v].pos;
            run_frame(vecs[v].exp_word, 0, 1'b0, 13'h0000);
        end

        // Position change after the latch must not leak into the current frame
        gray_en     = 1'b0;
        position_in = 13'h0A5C;
        run_frame(13'h0A5C, 0, 1'b1, 13'h1FFF);
        run_frame(13'h1FFF, 0, 1'b0, 13'h0000);

        // Fall during the monoflop restarts the pause and starts no frame
        position_in = 13'h0A5C;
        run_frame(13'h0A5C, 500, 1'b0, 13'h0000);
        run_frame(13'h0A5C, 0, 1'b0, 13'h0000);

        // Master stalls mid-frame
        partial_frame(13'h0A5C, 5);
        k = 0;
        while (busy !== 1'b0 && k < 20000) begin
            @(negedge clk75Mhz);
            k++;
        end
        ac_exp++;
        check("abort_cycles", 32'(k), 32'(LAT + AB));
        check("abort_do", 32'(ss_enc_do), 32'd1);
        check("abort_count", 32'(abort_count), 32'(ac_exp));
        check("abort_frame_count", 32'(frame_count), 32'(fc_exp));

        // Enable dropped after the sixth bit
        partial_frame(13'h0A5C, 6);
        repeat (HALF_LO) @(negedge clk75Mhz);
        enable = 1'b0;
        @(negedge clk75Mhz);
        check("dis_dat_dir", 32'(ss_enc_dat_dir), 32'd0);
        check("dis_do", 32'(ss_enc_do), 32'd1);
        check("dis_busy", 32'(busy), 32'd0);
        repeat (2000) @(negedge clk75Mhz);
        check("dis_frame_count", 32'(frame_count), 32'(fc_exp));
        check("dis_abort_count", 32'(abort_count), 32'(ac_exp));
        check("dis_queue", 32'(exp_q.size()), 32'd0);
        enable = 1'b1;
        repeat (3) @(negedge clk75Mhz);
        check("reen_dat_dir", 32'(ss_enc_dat_dir), 32'd1);
        gray_en = 1'b1;
        run_frame(13'h0F72, 0, 1'b0, 13'h0000);
        check("reen_abort_count", 32'(abort_count), 32'(ac_exp));

        // Asynchronous reset in the middle of a frame
        gray_en = 1'b0;
        partial_frame(13'h0A5C, 4);
        repeat (10) @(negedge clk75Mhz);
        #3 reset = 1'b0;
        #1;
        check("async_rst_do", 32'(ss_enc_do), 32'd1);
        check("async_rst_dat_dir", 32'(ss_enc_dat_dir), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_frame", 32'(frame_count), 32'd0);
        check("async_rst_abort", 32'(abort_count), 32'd0);
        fc_exp = 0;
        ac_exp = 0;
        exp_q.delete();
        @(negedge clk75Mhz);
        reset = 1'b1;
        repeat (3) @(negedge clk75Mhz);
        run_frame(13'h0A5C, 0, 1'b0, 13'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
